arbiter_rr_8: RTL

Eight-requester bus arbiter that shares one resource among requesters `req[7:0]` and grants exactly one at a time. It supports two modes: fixed priority, where bit 0 is highest (the same ordering as our 8-3 priority encoder), and round-robin with a rotating pointer. A grant is held until the owner drops its request or a hold timeout forces release. It sits in front of any shared datapath unit and drives that unit's select with `gnt_id`.

---
 rtl/arbiter_rr_8.sv | 76 +++++++
 1 files changed

// File: rtl/arbiter_rr_8.sv
// arbiter_rr_8: eight-way bus arbiter, fixed priority or round-robin, with a hold timeout
module arbiter_rr_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    localparam logic st_idle = 1'b0;
    localparam logic st_grant = 1'b1;
    localparam logic [7:0] hold_last = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    logic        state;
    logic [2:0]  ptr;
    logic [7:0]  cnt;
    logic [7:0]  mask;
    logic [7:0]  elig;
    logic [7:0]  rot;
    logic [15:0] dbl;
    logic [2:0]  fix_idx;
    logic [2:0]  rot_idx;
    logic [2:0]  win;
    logic        owner_req;
    logic        expire;
    assign elig = req & ~mask;
    // rotate so ptr lands at bit 0; a plain lowest-bit search then gives the round-robin winner
    assign dbl = {elig, elig} >> ptr;
    assign rot = dbl[7:0];
    always_comb begin
        fix_idx = 3'd0;
        rot_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            fix_idx = elig[i] ? 3'(i) : fix_idx;
            rot_idx = rot[i] ? 3'(i) : rot_idx;
        end
    end
    assign win = rr_mode ? ptr + rot_idx : fix_idx;
    assign owner_req = req[gnt_id];
    assign expire = (MAX_HOLD != 0) && (cnt == hold_last);
    assign gnt_valid = |gnt;
    always_ff @(posedge clk) begin
        timeout <= 1'b0;
        if (!rst_n) begin
            state <= st_idle;
            ptr <= 3'd0;
            cnt <= 8'd0;
            mask <= 8'd0;
            gnt <= 8'd0;
            gnt_id <= 3'd0;
        end else if (state == st_idle) begin
            if (enable) begin
                mask <= 8'd0;
                if (|elig) begin
                    gnt <= 8'd1 << win;
                    gnt_id <= win;
                    cnt <= 8'd0;
                    state <= st_grant;
                end
            end
        end else if (!owner_req || expire) begin
            // a request drop on the expiry edge is an ordinary release: no mask, no pulse
            gnt <= 8'd0;
            ptr <= gnt_id + 3'd1;
            state <= st_idle;
            mask <= owner_req ? (8'd1 << gnt_id) : 8'd0;
            timeout <= owner_req;
        end else begin
            cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
    end
endmodule
